// File: rtl/mem_sched_pkg.sv
// Shared types for the line-fill scheduler: FSM state encoding and width defaults.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_sched_pkg;

  localparam int ADDR_W_DEF = 27;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [2:0] {
    IDLE,
    WB_ISSUE,
    WB_WAIT,
    RD_ISSUE,
    RD_DATA,
    RESP
  } state_t;

endpackage

// File: rtl/mem_sched_rr_arb.sv
// Two-way round-robin grant with a last-grant register.
// Latency: grant is combinational; the pointer moves on the edge the grant is taken.
// Backpressure: the pointer only advances when the caller consumes the grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  // A lone requester wins outright; a tie goes to the port not served last.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
  end

  // Remember which port won once the grant is actually consumed.
  always_comb begin
    last_d = last_q;
    if (take) last_d = gnt[1];
  end

  // Pointer resets onto port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= 1'b1;
    else      last_q <= last_d;
  end

endmodule

// File: rtl/mem_sched.sv
// Line-fill scheduler: two miss ports share one DDR master, optional dirty writeback before each read.
// Latency: accept at cycle 0, rd_avalid at 1, resp_valid at 4 with zero-wait DDR; writeback adds its handshakes.
// Backpressure: req_ready only in IDLE; one transaction in flight; DDR channels held until handshaken.
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid0,
  input  logic              req_valid1,
  output logic              req_ready0,
  output logic              req_ready1,
  input  logic [ADDR_W-1:0] req_rd_addr0,
  input  logic [ADDR_W-1:0] req_rd_addr1,
  input  logic              req_wb0,
  input  logic              req_wb1,
  input  logic [ADDR_W-1:0] req_wb_addr0,
  input  logic [ADDR_W-1:0] req_wb_addr1,
  input  logic [LINE_W-1:0] req_wb_data0,
  input  logic [LINE_W-1:0] req_wb_data1,
  output logic              resp_valid0,
  output logic              resp_valid1,
  output logic [LINE_W-1:0] resp_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LINE_W-1:0] wr_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_avalid,
  input  logic              rd_aready,
  input  logic [LINE_W-1:0] rd_data,
  input  logic              rd_valid,
  output logic              rd_dready
);

  state_t            state_q, state_d;
  logic [1:0]        mask_q, mask_d;
  logic [1:0]        resp_valid_q, resp_valid_d;
  logic [LINE_W-1:0] resp_data_q, resp_data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LINE_W-1:0] wr_data_q, wr_data_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_avalid_q, rd_avalid_d;
  logic              rd_dready_q, rd_dready_d;

  logic [1:0] gnt, served;
  logic       merge, accept, wb_from0, wb_from1;

  // Same line requested by both ports: serve both with one DDR transaction.
  assign merge  = req_valid0 && req_valid1 && (req_rd_addr0 == req_rd_addr1);
  assign served = merge ? 2'b11 : gnt;
  assign accept = (state_q == IDLE) && (served != 2'b00);

  // Victim source: port 0 if it is served and dirty, otherwise port 1 if served and dirty.
  assign wb_from0 = served[0] && req_wb0;
  assign wb_from1 = served[1] && req_wb1 && !wb_from0;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({req_valid1, req_valid0}),
    .take (accept),
    .gnt  (gnt)
  );

  assign req_ready0  = (state_q == IDLE) && served[0];
  assign req_ready1  = (state_q == IDLE) && served[1];
  assign resp_valid0 = resp_valid_q[0];
  assign resp_valid1 = resp_valid_q[1];
  assign resp_data   = resp_data_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_valid    = wr_valid_q;
  assign rd_addr     = rd_addr_q;
  assign rd_avalid   = rd_avalid_q;
  assign rd_dready   = rd_dready_q;

  // Transaction sequencing: optional writeback, then read address, read data, response pulse.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    resp_valid_d = 2'b00;
    resp_data_d  = resp_data_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_valid_d   = wr_valid_q;
    rd_addr_d    = rd_addr_q;
    rd_avalid_d  = rd_avalid_q;
    rd_dready_d  = rd_dready_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mask_d    = served;
          rd_addr_d = served[0] ? req_rd_addr0 : req_rd_addr1;
          if (wb_from0 || wb_from1) begin
            wr_addr_d  = wb_from0 ? req_wb_addr0 : req_wb_addr1;
            wr_data_d  = wb_from0 ? req_wb_data0 : req_wb_data1;
            wr_valid_d = 1'b1;
            state_d    = WB_ISSUE;
          end else begin
            rd_avalid_d = 1'b1;
            state_d     = RD_ISSUE;
          end
        end
      end
      WB_ISSUE: begin
        if (wr_valid_q && wr_ready) begin
          wr_valid_d = 1'b0;
          state_d    = WB_WAIT;
        end
      end
      WB_WAIT: begin
        // The read must not overtake the victim write.
        if (wr_ready) begin
          rd_avalid_d = 1'b1;
          state_d     = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (rd_avalid_q && rd_aready) begin
          rd_avalid_d = 1'b0;
          rd_dready_d = 1'b1;
          state_d     = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rd_valid && rd_dready_q) begin
          resp_data_d = rd_data;
          rd_dready_d = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        resp_valid_d = mask_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      mask_q       <= 2'b00;
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_valid_q   <= 1'b0;
      rd_addr_q    <= '0;
      rd_avalid_q  <= 1'b0;
      rd_dready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_valid_q   <= wr_valid_d;
      rd_addr_q    <= rd_addr_d;
      rd_avalid_q  <= rd_avalid_d;
      rd_dready_q  <= rd_dready_d;
    end
  end

endmodule
